// File: rtl/calc_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | calc_seq : keypad-driven decimal calculator sequencer (add/sub/serial mul)  |
// | rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module calc_seq #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic             key_type,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] res,
  output logic             sign,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       disp_sel
);

  function automatic longint unsigned pow10(input int n);
    longint unsigned v;
    v = 64'd1;
    for (int i = 0; i < n; i++) v = v * 64'd10;
    return v;
  endfunction

  localparam longint unsigned MAXV = pow10(DIGITS) - 64'd1;
  localparam logic [2*WIDTH-1:0] MAXV_W = (2*WIDTH)'(MAXV);
  localparam int CW  = $clog2(DIGITS + 1);
  localparam int MCW = $clog2(WIDTH);

  generate
    if (WIDTH < $clog2(MAXV + 1)) begin : g_width_check
      $error("calc_seq: WIDTH too small to hold DIGITS decimal digits");
    end
  endgenerate

  localparam logic [2:0] S_A   = 3'd0;
  localparam logic [2:0] S_OP  = 3'd1;
  localparam logic [2:0] S_B   = 3'd2;
  localparam logic [2:0] S_MUL = 3'd3;
  localparam logic [2:0] S_RES = 3'd4;
  localparam logic [2:0] S_ERR = 3'd5;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  localparam logic [3:0] K_ADD = 4'b1010;
  localparam logic [3:0] K_SUB = 4'b1011;
  localparam logic [3:0] K_EQ  = 4'b1100;
  localparam logic [3:0] K_MUL = 4'b1101;
  localparam logic [3:0] K_BS  = 4'b1110;
  localparam logic [3:0] K_CLR = 4'b1111;

  localparam logic [MCW-1:0] MUL_LAST = MCW'(WIDTH - 1);

  logic [2:0]         state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op;
  logic [1:0]         chain_op;
  logic               chain;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [MCW-1:0]     mcnt;

  logic               accept;
  logic               is_clear;
  logic               is_digit;
  logic               is_oper;
  logic               is_eq;
  logic               is_bs;
  logic [1:0]         new_op;
  logic [WIDTH-1:0]   cur;
  logic [WIDTH-1:0]   cur_app;
  logic [WIDTH-1:0]   cur_bs;
  logic [WIDTH-1:0]   diff;
  logic               b_gt;
  logic [2*WIDTH-1:0] sum;
  logic [2*WIDTH-1:0] as_val;
  logic               as_neg;
  logic               as_ovf;
  logic [2*WIDTH-1:0] acc_next;
  logic               mul_ovf;
  logic               cnt_full;

  assign key_ready = (state != S_MUL);
  assign busy      = (state == S_MUL);

  // Clear bypasses key_ready so it can abort a multiply in flight.
  assign is_clear = key_type & (key_code == K_CLR);
  assign accept   = key_valid & (key_ready | is_clear);
  assign is_digit = accept & ~key_type & (key_code <= 4'd9);
  assign is_oper  = accept & key_type &
                    ((key_code == K_ADD) | (key_code == K_SUB) | (key_code == K_MUL));
  assign is_eq    = accept & key_type & (key_code == K_EQ);
  assign is_bs    = accept & key_type & (key_code == K_BS);

  always_comb begin
    new_op = OP_ADD;
    case (key_code)
      K_SUB:   new_op = OP_SUB;
      K_MUL:   new_op = OP_MUL;
      default: new_op = OP_ADD;
    endcase
  end

  assign cur      = (state == S_B) ? op_b : op_a;
  assign cur_app  = cur * WIDTH'(10) + WIDTH'(key_code);
  assign cur_bs   = cur / WIDTH'(10);
  assign cnt_full = (cnt >= CW'(DIGITS));

  assign b_gt   = (op_b > op_a);
  assign diff   = b_gt ? (op_b - op_a) : (op_a - op_b);
  assign sum    = {{WIDTH{1'b0}}, op_a} + {{WIDTH{1'b0}}, op_b};
  assign as_val = (op == OP_SUB) ? {{WIDTH{1'b0}}, diff} : sum;
  assign as_neg = (op == OP_SUB) & b_gt;
  assign as_ovf = (as_val > MAXV_W);

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_ovf  = (acc_next > MAXV_W);

  always_comb begin
    disp_sel = 2'd0;
    case (state)
      S_B, S_MUL: disp_sel = 2'd1;
      S_RES:      disp_sel = 2'd2;
      S_ERR:      disp_sel = 2'd3;
      default:    disp_sel = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_A;
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      sign     <= 1'b0;
      ovf      <= 1'b0;
      cnt      <= '0;
      op       <= OP_ADD;
      chain    <= 1'b0;
      chain_op <= OP_ADD;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      mcnt     <= '0;
    end else if (accept && is_clear) begin
      state    <= S_A;
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      sign     <= 1'b0;
      ovf      <= 1'b0;
      cnt      <= '0;
      op       <= OP_ADD;
      chain    <= 1'b0;
      chain_op <= OP_ADD;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      mcnt     <= '0;
    end else begin
      case (state)
        S_A: begin
          if (is_digit && !cnt_full) begin
            op_a <= cur_app;
            cnt  <= cnt + CW'(1);
          end else if (is_bs) begin
            op_a <= cur_bs;
            if (cnt != '0) cnt <= cnt - CW'(1);
          end else if (is_oper) begin
            op    <= new_op;
            op_b  <= '0;
            state <= S_OP;
          end
        end
        S_OP: begin
          if (is_digit) begin
            op_b  <= WIDTH'(key_code);
            cnt   <= CW'(1);
            state <= S_B;
          end else if (is_oper) begin
            op <= new_op;
          end
        end
        S_B: begin
          if (is_digit && !cnt_full) begin
            op_b <= cur_app;
            cnt  <= cnt + CW'(1);
          end else if (is_bs) begin
            op_b <= cur_bs;
            if (cnt != '0) cnt <= cnt - CW'(1);
          end else if (is_eq || is_oper) begin
            if (op == OP_MUL) begin
              state    <= S_MUL;
              acc      <= '0;
              mcand    <= {{WIDTH{1'b0}}, op_a};
              mplier   <= op_b;
              mcnt     <= '0;
              chain    <= is_oper;
              chain_op <= new_op;
            end else if (as_ovf) begin
              res   <= '0;
              sign  <= 1'b0;
              ovf   <= 1'b1;
              state <= S_ERR;
            end else begin
              res  <= as_val[WIDTH-1:0];
              sign <= as_neg;
              if (!is_oper) begin
                state <= S_RES;
              end else if (as_neg) begin
                state <= S_ERR;
              end else begin
                op_a  <= as_val[WIDTH-1:0];
                op_b  <= '0;
                op    <= new_op;
                state <= S_OP;
              end
            end
          end
        end
        S_MUL: begin
          // One multiplier bit per cycle; the final step resolves straight from acc_next.
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          mcnt   <= mcnt + MCW'(1);
          if (mcnt == MUL_LAST) begin
            sign <= 1'b0;
            if (mul_ovf) begin
              res   <= '0;
              ovf   <= 1'b1;
              state <= S_ERR;
            end else begin
              res <= acc_next[WIDTH-1:0];
              if (chain) begin
                op_a  <= acc_next[WIDTH-1:0];
                op_b  <= '0;
                op    <= chain_op;
                state <= S_OP;
              end else begin
                state <= S_RES;
              end
            end
          end
        end
        S_RES: begin
          if (is_oper) begin
            if (sign) begin
              state <= S_ERR;
            end else begin
              op_a  <= res;
              op_b  <= '0;
              op    <= new_op;
              state <= S_OP;
            end
          end else if (is_digit) begin
            op_a  <= WIDTH'(key_code);
            op_b  <= '0;
            res   <= '0;
            sign  <= 1'b0;
            ovf   <= 1'b0;
            cnt   <= CW'(1);
            state <= S_A;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_seq.sv
`default_nettype none
// tb_calc_seq: directed and randomized key sequences for calc_seq, compared
// against a behavioural calculator model held in the bench.
module tb_calc_seq;
  localparam int         DIGITS = 4;
  localparam int         WIDTH  = 16;
  localparam longint     MAXV   = 9999;
  localparam bit         T_DIG  = 1'b0;
  localparam bit         T_CMD  = 1'b1;
  localparam logic [3:0] K_ADD  = 4'hA;
  localparam logic [3:0] K_SUB  = 4'hB;
  localparam logic [3:0] K_EQ   = 4'hC;
  localparam logic [3:0] K_MUL  = 4'hD;
  localparam logic [3:0] K_BS   = 4'hE;
  localparam logic [3:0] K_CLR  = 4'hF;

  logic             clk       = 1'b0;
  logic             reset     = 1'b0;
  logic             key_valid = 1'b0;
  logic             key_type  = 1'b0;
  logic [3:0]       key_code  = 4'd0;
  logic             key_ready;
  logic [WIDTH-1:0] op_a, op_b, res;
  logic             sign, ovf, busy;
  logic [1:0]       disp_sel;

  int checks   = 0;
  int failures = 0;

  calc_seq #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_type(key_type),
    .key_code(key_code), .key_ready(key_ready), .op_a(op_a), .op_b(op_b),
    .res(res), .sign(sign), .ovf(ovf), .busy(busy), .disp_sel(disp_sel)
  );

  always #5 clk = ~clk;

  // Calculator model: which operand is being typed, plain integer values.
  typedef enum int {P_A, P_OP, P_B, P_RES, P_ERR} phase_t;
  phase_t     m_ph;
  longint     m_a, m_b, m_res;
  bit         m_neg, m_ovf, m_mul;
  int         m_n;
  logic [3:0] m_op;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = P_A; m_a = 0; m_b = 0; m_res = 0; m_neg = 0; m_ovf = 0;
    m_mul = 0; m_n = 0; m_op = K_ADD;
  endtask

  function automatic logic [1:0] exp_disp();
    case (m_ph)
      P_B:     return 2'd1;
      P_RES:   return 2'd2;
      P_ERR:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic model_key(input bit t, input logic [3:0] c);
    bit     dig, opk, neg;
    longint v;
    dig = (t == T_DIG) && (c <= 4'd9);
    opk = (t == T_CMD) && (c == K_ADD || c == K_SUB || c == K_MUL);
    neg = 0;
    if (t == T_CMD && c == K_CLR) begin
      model_reset();
      return;
    end
    case (m_ph)
      P_A: begin
        if (dig) begin
          if (m_n < DIGITS) begin m_a = m_a * 10 + longint'(c); m_n++; end
        end else if (t == T_CMD && c == K_BS) begin
          m_a = m_a / 10; if (m_n > 0) m_n--;
        end else if (opk) begin
          m_op = c; m_b = 0; m_ph = P_OP;
        end
      end
      P_OP: begin
        if (dig) begin m_b = longint'(c); m_n = 1; m_ph = P_B; end
        else if (opk) m_op = c;
      end
      P_B: begin
        if (dig) begin
          if (m_n < DIGITS) begin m_b = m_b * 10 + longint'(c); m_n++; end
        end else if (t == T_CMD && c == K_BS) begin
          m_b = m_b / 10; if (m_n > 0) m_n--;
        end else if (opk || (t == T_CMD && c == K_EQ)) begin
          if (m_op == K_ADD) v = m_a + m_b;
          else if (m_op == K_SUB) begin
            if (m_b > m_a) begin v = m_b - m_a; neg = 1; end
            else v = m_a - m_b;
          end else begin
            v = m_a * m_b; m_mul = 1;
          end
          if (v > MAXV) begin
            m_res = 0; m_ovf = 1; m_neg = 0; m_ph = P_ERR;
          end else begin
            m_res = v; m_neg = neg;
            if (!opk) m_ph = P_RES;
            else if (neg) m_ph = P_ERR;
            else begin m_a = v; m_b = 0; m_op = c; m_ph = P_OP; end
          end
        end
      end
      P_RES: begin
        if (opk) begin
          if (m_neg) m_ph = P_ERR;
          else begin m_a = m_res; m_b = 0; m_op = c; m_ph = P_OP; end
        end else if (dig) begin
          m_a = longint'(c); m_b = 0; m_res = 0; m_neg = 0; m_ovf = 0;
          m_n = 1; m_ph = P_A;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    check("op_a", op_a, m_a);
    check("op_b", op_b, m_b);
    check("res", res, m_res);
    check("sign", sign, m_neg);
    check("ovf", ovf, m_ovf);
    check("disp_sel", disp_sel, exp_disp());
    check("busy_idle", busy, 0);
    check("key_ready_idle", key_ready, 1);
  endtask

  // Called at a falling edge; the key is sampled on the next rising edge.
  task automatic press(input bit t, input logic [3:0] c,
                       input int poke_at = -1, input int abort_at = -1);
    key_valid = 1'b1; key_type = t; key_code = c;
    @(negedge clk);
    key_valid = 1'b0;
    model_key(t, c);
    if (m_mul) begin
      m_mul = 0;
      for (int i = 0; i < WIDTH; i++) begin
        check("busy_mul", busy, 1);
        check("key_ready_mul", key_ready, 0);
        if (i == abort_at) begin
          key_valid = 1'b1; key_type = T_CMD; key_code = K_CLR;
          @(negedge clk);
          key_valid = 1'b0;
          model_reset();
          break;
        end
        if (i == poke_at) begin
          key_valid = 1'b1; key_type = T_DIG; key_code = 4'd5;
        end
        @(negedge clk);
        key_valid = 1'b0;
      end
    end
    check_outputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk); @(negedge clk);
    check_outputs();
    reset = 1'b1;

    // 12 + 7
    press(T_DIG, 4'd1); press(T_DIG, 4'd2); press(T_CMD, K_ADD);
    press(T_DIG, 4'd7); press(T_CMD, K_EQ);
    check("r26_op_a", op_a, 12); check("r26_op_b", op_b, 7);
    check("r26_res", res, 19); check("r26_sign", sign, 0); check("r26_disp", disp_sel, 2);

    // negative result, then error and clear
    press(T_CMD, K_CLR);
    press(T_DIG, 4'd5); press(T_CMD, K_SUB); press(T_DIG, 4'd8); press(T_CMD, K_EQ);
    check("r27_res", res, 3); check("r27_sign", sign, 1);
    press(T_CMD, K_ADD);
    check("r27_err_disp", disp_sel, 3);
    press(T_DIG, 4'd4);
    check("r27_ignored_disp", disp_sel, 3);
    press(T_CMD, K_CLR);
    check("r27_clr_res", res, 0); check("r27_clr_disp", disp_sel, 0);

    // digit limit and backspace
    press(T_DIG, 4'd1); press(T_DIG, 4'd2); press(T_DIG, 4'd3);
    press(T_DIG, 4'd4); press(T_DIG, 4'd5);
    check("r28_limit", op_a, 1234);
    press(T_CMD, K_BS);
    check("r28_bs", op_a, 123);
    press(T_DIG, 4'd6);
    check("r28_append", op_a, 1236);

    // multiply with ignored strobe, then chain, then overflow
    press(T_CMD, K_CLR);
    press(T_DIG, 4'd9); press(T_DIG, 4'd9); press(T_CMD, K_MUL);
    press(T_DIG, 4'd9); press(T_DIG, 4'd9); press(T_CMD, K_EQ, 3);
    check("r29_mul", res, 9801);
    press(T_CMD, K_ADD); press(T_DIG, 4'd1); press(T_CMD, K_EQ);
    check("r29_add_res", res, 9802); check("r29_add_ovf", ovf, 0);
    press(T_DIG, 4'd1); press(T_DIG, 4'd0); press(T_DIG, 4'd0); press(T_CMD, K_MUL);
    press(T_DIG, 4'd1); press(T_DIG, 4'd0); press(T_DIG, 4'd0); press(T_CMD, K_EQ);
    check("r29_ovf", ovf, 1); check("r29_ovf_res", res, 0); check("r29_ovf_disp", disp_sel, 3);

    // clear aborts a multiply on its fifth cycle
    press(T_CMD, K_CLR);
    press(T_DIG, 4'd9); press(T_CMD, K_MUL); press(T_DIG, 4'd9);
    press(T_CMD, K_EQ, -1, 4);
    check("r30_abort_busy", busy, 0); check("r30_abort_res", res, 0);

    // chained operator resolves the pending add
    press(T_DIG, 4'd3); press(T_CMD, K_ADD); press(T_DIG, 4'd4); press(T_CMD, K_MUL);
    check("r31_chain_a", op_a, 7);
    press(T_DIG, 4'd2); press(T_CMD, K_EQ);
    check("r31_res", res, 14);

    // randomized key stream
    press(T_CMD, K_CLR);
    for (int k = 0; k < 400; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 50)      press(T_DIG, 4'($urandom_range(0, 9)));
      else if (r < 53) press(T_DIG, 4'($urandom_range(10, 15)));
      else if (r < 56) press(T_CMD, 4'($urandom_range(0, 9)));
      else if (r < 74) begin
        case ($urandom_range(0, 2))
          0:       press(T_CMD, K_ADD);
          1:       press(T_CMD, K_SUB);
          default: press(T_CMD, K_MUL);
        endcase
      end
      else if (r < 84) press(T_CMD, K_EQ);
      else if (r < 93) press(T_CMD, K_BS);
      else             press(T_CMD, K_CLR);
    end

    // asynchronous reset between clock edges while entering operand B
    press(T_CMD, K_CLR);
    press(T_DIG, 4'd4); press(T_CMD, K_SUB); press(T_DIG, 4'd2);
    check("async_pre_opb", op_b, 2);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
    check_outputs();
    press(T_DIG, 4'd8);
    check("post_reset_key", op_a, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_seq.md
CALC_SEQ -- requirements
Module: calc_seq

Interface
REQ-001 Parameter DIGITS, default 4: maximum decimal digits per operand and per result.
REQ-002 Parameter WIDTH, default 16: binary width of operands and result; SHALL be >= ceil(log2(10^DIGITS)), otherwise elaboration error.
REQ-003 Localparam MAXV = 10^DIGITS-1.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 key_valid  in  1  one-cycle strobe, key present.
REQ-007 key_type  in  1  0 = digit, 1 = command.
REQ-008 key_code  in  4  digit 0-9, or command code per REQ-011.
REQ-009 key_ready  out  1  high when a key strobe will be accepted.
REQ-010 op_a, op_b, res  out  WIDTH each  operand A, operand B, result magnitude; sign  out  1  result negative; ovf  out  1  result > MAXV; busy  out  1  multiply in progress; disp_sel  out  2  0=A, 1=B, 2=result, 3=error/blank.

Function
REQ-011 Commands: 1010 add, 1011 sub, 1101 mul, 1100 equals, 1110 backspace, 1111 clear; other command codes and digit codes >9 SHALL be ignored.
REQ-012 A key is accepted only on the cycle key_valid=1 and key_ready=1; exception: clear is accepted even when busy=1.
REQ-013 States: S_A, S_OP, S_B, S_MUL, S_RES, S_ERR.
REQ-014 S_A: digit with count<DIGITS -> op_a=op_a*10+d, count+1; at count=DIGITS digit ignored; backspace -> op_a=op_a/10, count-1 (floor 0); operator -> latch op, op_b=0, S_OP; equals ignored; disp_sel=0.
REQ-015 S_OP: digit -> op_b=d, count=1, S_B, disp_sel=1; operator -> replaces latched op; equals/backspace ignored.
REQ-016 S_B: digit/backspace as REQ-014 on op_b; equals -> compute; operator -> compute, then chain per REQ-020 with the new op.
REQ-017 Add/sub compute: res, sign, ovf registered one cycle after acceptance, S_RES, disp_sel=2; sub with op_b>op_a -> res=op_b-op_a, sign=1.
REQ-018 Mul compute: S_MUL, busy=1, key_ready=0 for exactly WIDTH cycles, shift-add into a 2*WIDTH accumulator; res valid and S_RES on cycle WIDTH+1 after acceptance.
REQ-019 Any result > MAXV -> ovf=1, res=0, S_ERR, disp_sel=3.
REQ-020 S_RES: operator with sign=0 -> op_a=res, op_b=0, S_OP; operator with sign=1 -> S_ERR, disp_sel=3; digit -> op_a=d, op_b=0, res/sign/ovf cleared, S_A; equals/backspace ignored.
REQ-021 S_ERR: all keys except clear ignored.
REQ-022 Clear in any state (including S_MUL, aborting the multiply) -> reset values of REQ-024 on the next edge.
REQ-023 key_ready = 0 only in S_MUL; busy = 1 only in S_MUL.

Reset
REQ-024 reset=0 asynchronously forces S_A, op_a=op_b=res=0, sign=ovf=busy=0, count=0, latched op=add, disp_sel=0, key_ready=1; takes effect mid-entry or mid-multiply without waiting for clk.
REQ-025 Release of reset is synchronous to clk; first key accepted on the first rising edge with reset=1.

Verification
REQ-026 Keys 1,2,add,7,equals -> op_a=12, op_b=7, res=19, sign=0, disp_sel=2 one cycle after the equals strobe.
REQ-027 Keys 5,sub,8,equals -> res=3, sign=1; then add -> S_ERR, disp_sel=3; then 4 -> ignored; then clear -> all outputs at reset values.
REQ-028 Keys 1,2,3,4,5 -> op_a=1234 (fifth ignored); backspace -> op_a=123; 6 -> op_a=1236.
REQ-029 Keys 9,9,mul,9,9,equals -> busy=1 and key_ready=0 for 16 cycles, a digit strobe during busy ignored, res=9801 on cycle 17; then add,1,equals -> ovf=0, res=9802; keys 1,0,0,mul,1,0,0,equals -> ovf=1, res=0, disp_sel=3.
REQ-030 Clear strobe on cycle 5 of a multiply -> busy=0, all outputs at reset values on the next edge; reset=0 pulse between clk edges during S_B -> outputs at reset values immediately.
REQ-031 Chaining: 3,add,4,mul -> op_a=7, S_OP; 2,equals -> res=14 after WIDTH+1 cycles.
